// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - opcode enum, operand/result types and the shared ALU function
package instr_register_pkg;

    // Widest operand the shared ALU handles; narrower instances sign-extend into it
    localparam int MAX_OPERAND_W = 32;
    localparam int MAX_RESULT_W  = 2 * MAX_OPERAND_W;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [MAX_OPERAND_W-1:0] operand_t;
    typedef logic signed [MAX_RESULT_W-1:0]  result_t;

    typedef struct packed {
        result_t result;
        logic    err;
    } alu_out_t;

    // Full-width signed arithmetic; division by zero and unknown opcodes report err with a zero result
    function automatic alu_out_t alu_compute(input opcode_t opc, input operand_t a, input operand_t b);
        alu_out_t o;
        result_t  ax;
        result_t  bx;
        ax = {{MAX_OPERAND_W{a[MAX_OPERAND_W-1]}}, a};
        bx = {{MAX_OPERAND_W{b[MAX_OPERAND_W-1]}}, b};
        o.result = '0;
        o.err    = 1'b0;
        case (opc)
            ZERO:  o.result = '0;
            PASSA: o.result = ax;
            PASSB: o.result = bx;
            ADD:   o.result = ax + bx;
            SUB:   o.result = ax - bx;
            MULT:  o.result = ax * bx;
            DIV: begin
                if (b == '0) o.err = 1'b1;
                else         o.result = ax / bx;
            end
            MOD: begin
                if (b == '0) o.err = 1'b1;
                else         o.result = ax % bx;
            end
            default: o.err = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/instr_alu_stage.sv
// rtl/instr_alu_stage.sv - two-stage capture/compute pipeline feeding the register file write port
module instr_alu_stage
    import instr_register_pkg::*;
#(
    parameter int OPERAND_W = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_load,
    input  opcode_t                       i_opcode,
    input  logic signed [OPERAND_W-1:0]   i_operand_a,
    input  logic signed [OPERAND_W-1:0]   i_operand_b,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic                          o_s1_valid,
    output logic                          o_s2_valid,
    output logic [ADDR_W-1:0]             o_s2_addr,
    output opcode_t                       o_s2_opcode,
    output logic signed [OPERAND_W-1:0]   o_s2_operand_a,
    output logic signed [OPERAND_W-1:0]   o_s2_operand_b,
    output logic signed [2*OPERAND_W-1:0] o_s2_result,
    output logic                          o_s2_err
);

    logic                          r_s1_valid;
    opcode_t                       r_s1_opcode;
    logic signed [OPERAND_W-1:0]   r_s1_a;
    logic signed [OPERAND_W-1:0]   r_s1_b;
    logic [ADDR_W-1:0]             r_s1_addr;

    logic                          r_s2_valid;
    opcode_t                       r_s2_opcode;
    logic signed [OPERAND_W-1:0]   r_s2_a;
    logic signed [OPERAND_W-1:0]   r_s2_b;
    logic [ADDR_W-1:0]             r_s2_addr;
    logic signed [2*OPERAND_W-1:0] r_s2_result;
    logic                          r_s2_err;

    operand_t                      w_a_ext;
    operand_t                      w_b_ext;
    alu_out_t                      w_alu;
    logic                          w_unused_alu;

    // Sign-extend S1 operands to the shared ALU width
    always_comb begin
        w_a_ext = {MAX_OPERAND_W{r_s1_a[OPERAND_W-1]}};
        w_b_ext = {MAX_OPERAND_W{r_s1_b[OPERAND_W-1]}};
        w_a_ext[OPERAND_W-1:0] = r_s1_a;
        w_b_ext[OPERAND_W-1:0] = r_s1_b;
    end

    assign w_alu = alu_compute(r_s1_opcode, w_a_ext, w_b_ext);

    // Upper ALU bits only carry information when OPERAND_W equals the package maximum
    assign w_unused_alu = ^w_alu.result;

    // S1: capture accepted load inputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_opcode <= ZERO;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_addr   <= '0;
        end else begin
            r_s1_valid <= i_load;
            if (i_load) begin
                r_s1_opcode <= i_opcode;
                r_s1_a      <= i_operand_a;
                r_s1_b      <= i_operand_b;
                r_s1_addr   <= i_addr;
            end
        end
    end

    // S2: register the ALU result alongside the instruction fields
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_opcode <= ZERO;
            r_s2_a      <= '0;
            r_s2_b      <= '0;
            r_s2_addr   <= '0;
            r_s2_result <= '0;
            r_s2_err    <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_opcode <= r_s1_opcode;
                r_s2_a      <= r_s1_a;
                r_s2_b      <= r_s1_b;
                r_s2_addr   <= r_s1_addr;
                r_s2_result <= w_alu.result[2*OPERAND_W-1:0];
                r_s2_err    <= w_alu.err;
            end
        end
    end

    assign o_s1_valid     = r_s1_valid;
    assign o_s2_valid     = r_s2_valid;
    assign o_s2_addr      = r_s2_addr;
    assign o_s2_opcode    = r_s2_opcode;
    assign o_s2_operand_a = r_s2_a;
    assign o_s2_operand_b = r_s2_b;
    assign o_s2_result    = r_s2_result;
    assign o_s2_err       = r_s2_err;

endmodule

// File: rtl/instr_register_pipe.sv
// rtl/instr_register_pipe.sv - pipelined instruction register file with bypassed read port and clear sweep
module instr_register_pipe
    import instr_register_pkg::*;
#(
    parameter int  OPERAND_W = 32,
    parameter int  DEPTH     = 32,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int INSTR_W   = $bits(opcode_t) + 4*OPERAND_W + 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  opcode_t                     opcode,
    input  logic signed [OPERAND_W-1:0] operand_a,
    input  logic signed [OPERAND_W-1:0] operand_b,
    input  logic [ADDR_W-1:0]           write_pointer,
    input  logic                        clear_req,
    input  logic                        read_en,
    input  logic [ADDR_W-1:0]           read_pointer,
    output logic                        rd_valid,
    output logic [INSTR_W-1:0]          instruction_word,
    output logic [ADDR_W:0]             load_count
);

    typedef struct packed {
        opcode_t                       opc;
        logic signed [OPERAND_W-1:0]   op_a;
        logic signed [OPERAND_W-1:0]   op_b;
        logic signed [2*OPERAND_W-1:0] result;
        logic                          err;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    instr_t                        r_mem [DEPTH];
    instr_t                        r_rd_word;
    logic                          r_rd_valid;
    logic [ADDR_W:0]               r_load_count;
    state_t                        r_state;
    logic                          r_load_ready;
    logic [ADDR_W-1:0]             r_sweep_addr;

    logic                          w_accept;
    logic                          w_s1_valid;
    logic                          w_s2_valid;
    logic [ADDR_W-1:0]             w_s2_addr;
    opcode_t                       w_s2_opcode;
    logic signed [OPERAND_W-1:0]   w_s2_a;
    logic signed [OPERAND_W-1:0]   w_s2_b;
    logic signed [2*OPERAND_W-1:0] w_s2_result;
    logic                          w_s2_err;
    logic                          w_drained;
    logic                          w_wr_en;
    logic [ADDR_W-1:0]             w_wr_addr;
    instr_t                        w_wr_data;

    // Ready drops with reset_n so no load is offered while reset is held
    assign load_ready = r_load_ready & reset_n;
    assign w_accept   = load_valid & load_ready;
    assign w_drained  = !w_s1_valid && !w_s2_valid;

    instr_alu_stage #(
        .OPERAND_W (OPERAND_W),
        .ADDR_W    (ADDR_W)
    ) u_alu_stage (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_load         (w_accept),
        .i_opcode       (opcode),
        .i_operand_a    (operand_a),
        .i_operand_b    (operand_b),
        .i_addr         (write_pointer),
        .o_s1_valid     (w_s1_valid),
        .o_s2_valid     (w_s2_valid),
        .o_s2_addr      (w_s2_addr),
        .o_s2_opcode    (w_s2_opcode),
        .o_s2_operand_a (w_s2_a),
        .o_s2_operand_b (w_s2_b),
        .o_s2_result    (w_s2_result),
        .o_s2_err       (w_s2_err)
    );

    // Single write port: sweep zeroing owns it while clearing, otherwise the S2 commit
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (r_state == ST_SWEEP) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_sweep_addr;
        end else if (w_s2_valid) begin
            w_wr_en          = 1'b1;
            w_wr_addr        = w_s2_addr;
            w_wr_data.opc    = w_s2_opcode;
            w_wr_data.op_a   = w_s2_a;
            w_wr_data.op_b   = w_s2_b;
            w_wr_data.result = w_s2_result;
            w_wr_data.err    = w_s2_err;
        end
    end

    // Storage array; later commits to the same address simply overwrite earlier ones
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Registered read port, write-first when reading the address written on the same edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_word  <= '0;
        end else begin
            r_rd_valid <= read_en;
            if (read_en) begin
                if (w_wr_en && (w_wr_addr == read_pointer)) r_rd_word <= w_wr_data;
                else                                        r_rd_word <= r_mem[read_pointer];
            end
        end
    end

    // Committed-write counter, saturating at DEPTH and zeroed when the sweep begins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_load_count <= '0;
        end else if (r_state == ST_DRAIN && w_drained) begin
            r_load_count <= '0;
        end else if (w_s2_valid && (r_load_count != (ADDR_W+1)'(DEPTH))) begin
            r_load_count <= r_load_count + 1'b1;
        end
    end

    // Clear sequencer: stop loads, let the pipeline empty, then zero one entry per cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_load_ready <= 1'b1;
            r_sweep_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state      <= ST_DRAIN;
                        r_load_ready <= 1'b0;
                    end else begin
                        r_load_ready <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state      <= ST_SWEEP;
                        r_sweep_addr <= '0;
                    end
                end
                ST_SWEEP: begin
                    r_sweep_addr <= r_sweep_addr + 1'b1;
                    if (r_sweep_addr == ADDR_W'(DEPTH-1)) begin
                        r_state      <= ST_IDLE;
                        r_load_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rd_valid         = r_rd_valid;
    assign instruction_word = r_rd_word;
    assign load_count       = r_load_count;

endmodule

// File: tb/tb_instr_register_pipe.sv
// tb/tb_instr_register_pipe.sv - directed self-checking bench for instr_register_pipe
module tb_instr_register_pipe;
    import instr_register_pkg::*;

    typedef struct packed {
        logic [2:0]         opc;
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic signed [63:0] res;
        logic               err;
    } w32_t;

    typedef struct packed {
        logic [2:0]         opc;
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [31:0] res;
        logic               err;
    } w16_t;

    logic               clk;
    logic               rst_n;
    logic               load_valid;
    logic               load_ready;
    opcode_t            opcode;
    logic signed [31:0] operand_a;
    logic signed [31:0] operand_b;
    logic [4:0]         write_pointer;
    logic               clear_req;
    logic               read_en;
    logic [4:0]         read_pointer;
    logic               rd_valid;
    logic [131:0]       instruction_word;
    logic [5:0]         load_count;

    logic               rst16_n;
    logic               l16_valid;
    logic               l16_ready;
    opcode_t            op16;
    logic signed [15:0] a16;
    logic signed [15:0] b16;
    logic [2:0]         wp16;
    logic               clr16;
    logic               re16;
    logic [2:0]         rp16;
    logic               v16;
    logic [67:0]        word16;
    logic [3:0]         cnt16;

    int n_chk = 0;
    int n_bad = 0;

    instr_register_pipe #(.OPERAND_W(32), .DEPTH(32)) u_dut (
        .clk              (clk),
        .reset_n          (rst_n),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .clear_req        (clear_req),
        .read_en          (read_en),
        .read_pointer     (read_pointer),
        .rd_valid         (rd_valid),
        .instruction_word (instruction_word),
        .load_count       (load_count)
    );

    instr_register_pipe #(.OPERAND_W(16), .DEPTH(8)) u_dut16 (
        .clk              (clk),
        .reset_n          (rst16_n),
        .load_valid       (l16_valid),
        .load_ready       (l16_ready),
        .opcode           (op16),
        .operand_a        (a16),
        .operand_b        (b16),
        .write_pointer    (wp16),
        .clear_req        (clr16),
        .read_en          (re16),
        .read_pointer     (rp16),
        .rd_valid         (v16),
        .instruction_word (word16),
        .load_count       (cnt16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [131:0] got, input logic [131:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input opcode_t op, input int a, input int b, input int ptr);
        int n;
        n = 0;
        while (!load_ready && n < 100) begin
            tick();
            n++;
        end
        if (!load_ready) chk("load_ready_timeout", load_ready, 1'b1);
        load_valid    = 1'b1;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        write_pointer = 5'(ptr);
        tick();
        load_valid    = 1'b0;
    endtask

    task automatic rd_a(input int ptr, output w32_t w);
        read_en      = 1'b1;
        read_pointer = 5'(ptr);
        tick();
        w       = instruction_word;
        read_en = 1'b0;
        chk("rd_valid", rd_valid, 1'b1);
    endtask

    initial begin
        w32_t w;
        w16_t v;
        int   low;

        rst_n = 1'b0; load_valid = 1'b0; opcode = ZERO; operand_a = '0; operand_b = '0;
        write_pointer = '0; clear_req = 1'b0; read_en = 1'b0; read_pointer = '0;
        rst16_n = 1'b0; l16_valid = 1'b0; op16 = ZERO; a16 = '0; b16 = '0;
        wp16 = '0; clr16 = 1'b0; re16 = 1'b0; rp16 = '0;

        // T1: reset
        tick();
        tick();
        chk("t1_ready_in_reset", load_ready, 1'b0);
        chk("t1_rd_valid", rd_valid, 1'b0);
        chk("t1_count", load_count, 0);
        chk("t1_word", instruction_word, 0);
        rst_n   = 1'b1;
        rst16_n = 1'b1;
        #1;
        chk("t1_ready_after", load_ready, 1'b1);
        rd_a(0, w);
        chk("t1_entry0", w, 0);
        rd_a(31, w);
        chk("t1_entry31", w, 0);

        // T2: ADD / MULT with exact 2-cycle write latency
        load_a(ADD, 5, -7, 3);
        read_en      = 1'b1;
        read_pointer = 5'd3;
        load_a(MULT, -3, 4, 4);
        w = instruction_word;
        chk("t2_not_early", w, 0);
        rd_a(3, w);
        chk("t2_add_opc", w.opc, ADD);
        chk("t2_add_res", w.res, -2);
        chk("t2_add_err", w.err, 1'b0);
        rd_a(4, w);
        chk("t2_mult_res", w.res, -12);
        chk("t2_mult_a", w.a, -3);
        tick();
        chk("t2_rd_idle", rd_valid, 1'b0);
        w = instruction_word;
        chk("t2_word_hold", w.res, -12);

        // T3: divide by zero and signed mod/div
        load_a(DIV, 9, 0, 1);
        load_a(MOD, -7, 2, 2);
        load_a(DIV, -7, 2, 6);
        tick();
        tick();
        rd_a(1, w);
        chk("t3_div0_opc", w.opc, DIV);
        chk("t3_div0_res", w.res, 0);
        chk("t3_div0_err", w.err, 1'b1);
        rd_a(2, w);
        chk("t3_mod_res", w.res, -1);
        chk("t3_mod_err", w.err, 1'b0);
        rd_a(6, w);
        chk("t3_div_res", w.res, -3);

        // T4: back-to-back writes to one address, bypass on each write edge
        load_a(PASSA, 1, 0, 7);
        load_a(PASSA, 2, 0, 7);
        rd_a(7, w);
        chk("t4_first_bypass", w.res, 1);
        rd_a(7, w);
        chk("t4_second_a", w.a, 2);
        chk("t4_second_res", w.res, 2);
        tick();
        rd_a(7, w);
        chk("t4_stored", w.res, 2);
        chk("t4_count", load_count, 7);

        // T5: clear with loads still in flight
        load_a(PASSA, 10, 0, 10);
        load_a(PASSA, 11, 0, 11);
        clear_req = 1'b1;
        load_a(PASSA, 12, 0, 12);
        clear_req = 1'b0;
        low = 0;
        while (!load_ready && low < 200) begin
            clear_req = (low == 10);
            low++;
            tick();
        end
        clear_req = 1'b0;
        chk("t5_low_cycles", low, 3 + 32);
        chk("t5_count", load_count, 0);
        tick();
        tick();
        chk("t5_ready_stays", load_ready, 1'b1);
        for (int i = 0; i < 32; i++) begin
            rd_a(i, w);
            chk("t5_entry_zero", w, 0);
        end

        // Reset with two loads in flight discards them
        load_a(PASSA, 99, 0, 5);
        load_a(PASSA, 98, 0, 6);
        rst_n = 1'b0;
        tick();
        chk("rst_ready_low", load_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_word", instruction_word, 0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_count", load_count, 0);
        rd_a(5, w);
        chk("rst_entry5", w, 0);
        rd_a(6, w);
        chk("rst_entry6", w, 0);

        // T6: 16-bit operands, 8 entries, pointer wrap
        chk("t6_ready", l16_ready, 1'b1);
        l16_valid = 1'b1;
        op16 = MULT;  a16 = 16'sh7FFF; b16 = 16'sh7FFF; wp16 = 3'd7;
        tick();
        op16 = PASSB; a16 = 16'sd0;    b16 = -16'sd5;   wp16 = wp16 + 3'd1;
        tick();
        op16 = SUB;   a16 = -16'sd32768; b16 = 16'sd1;  wp16 = wp16 + 3'd1;
        tick();
        l16_valid = 1'b0;
        tick();
        tick();
        re16 = 1'b1;
        rp16 = 3'd7;
        tick();
        v = word16;
        chk("t6_mult_res", v.res, 32'sh3FFF0001);
        chk("t6_mult_a", v.a, 16'sh7FFF);
        chk("t6_valid", v16, 1'b1);
        rp16 = 3'd0;
        tick();
        v = word16;
        chk("t6_wrap_b", v.b, -5);
        chk("t6_wrap_res", v.res, -5);
        rp16 = 3'd1;
        tick();
        v = word16;
        chk("t6_sub_res", v.res, -32769);
        re16 = 1'b0;
        chk("t6_count", cnt16, 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
